// File: rtl/btn_mode_ctrl.sv
// Button front end: two-flop synchronisers, per-button debounce, press and
// long-press pulses, and the watch/stopwatch/timer mode register.
module btn_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES   = 500000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter int unsigned MODE_BTN          = 0,
    parameter int unsigned NUM_MODES         = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] btn,
    output logic [7:0] btn_level,
    output logic [7:0] btn_press,
    output logic [7:0] btn_long,
    output logic [3:0] mode,
    output logic       mode_changed
);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DW-1:0] D_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX     = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] H_PRE     = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [3:0]    MODE_LAST = 4'(NUM_MODES - 1);
    localparam logic [2:0]    MB        = 3'(MODE_BTN);

    logic [7:0] s1;
    logic [7:0] s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_bit
        logic [DW-1:0] dcnt;
        logic [HW-1:0] hcnt;
        logic          level_r;
        logic          press_r;
        logic          long_r;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dcnt    <= '0;
                hcnt    <= '0;
                level_r <= 1'b0;
                press_r <= 1'b0;
                long_r  <= 1'b0;
            end else begin
                press_r <= 1'b0;
                long_r  <= 1'b0;

                if (s2[g] != level_r) begin
                    if (dcnt == D_LAST) begin
                        level_r <= s2[g];
                        press_r <= s2[g];
                        dcnt    <= '0;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end else begin
                    dcnt <= '0;
                end

                // Hold count follows the registered level, so it starts the
                // edge after the press pulse and saturates to stop repeats.
                if (!level_r) begin
                    hcnt <= '0;
                end else if (hcnt != H_MAX) begin
                    hcnt   <= hcnt + HW'(1);
                    long_r <= (hcnt == H_PRE);
                end
            end
        end

        assign btn_level[g] = level_r;
        assign btn_press[g] = press_r;
        assign btn_long[g]  = long_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode         <= '0;
            mode_changed <= 1'b0;
        end else begin
            mode_changed <= btn_press[MB];
            if (btn_press[MB]) begin
                mode <= (mode == MODE_LAST) ? '0 : mode + 4'd1;
            end
        end
    end

endmodule

// File: doc/btn_mode_ctrl.md
# btn_mode_ctrl

Button conditioning and mode-sequencing front end for the watch top level. Synchronises and debounces the eight raw push-buttons, and produces clean level, press-pulse and long-press-pulse vectors. Owns the display-mode register that selects watch / stopwatch / timer, whose `mode` output is the 4-bit mode flag consumed by the top level and the three function blocks.

## Interface

- `DEBOUNCE_CYCLES`, default 500000: consecutive clock cycles a synchronised input must differ from the debounced level before the level flips; legal range 2..2^20.
- `LONG_PRESS_CYCLES`, default 50000000: cycles a debounced level must stay high before a long-press pulse is emitted; must exceed `DEBOUNCE_CYCLES`.
- `MODE_BTN`, default 0: index of the button that advances the mode.
- `NUM_MODES`, default 3: number of modes; legal range 2..16. Mode 0 is watch, 1 is stopwatch, 2 is timer.

Ports:

- `clk` input 1: system clock, single clock domain.
- `rst` input 1: asynchronous, active-high reset.
- `btn` input 8: raw buttons, asynchronous, active-high.
- `btn_level` output 8: debounced button levels.
- `btn_press` output 8: one-cycle pulse per debounced rising edge.
- `btn_long` output 8: one-cycle pulse when a button has been held for `LONG_PRESS_CYCLES`.
- `mode` output 4: current mode, 0..NUM_MODES-1.
- `mode_changed` output 1: one-cycle pulse in the first cycle `mode` shows a new value.

## Operation

- **Per-bit synchroniser:** two flops, `s1` then `s2`, reset to 0.
- **Per-bit debounce counter `dcnt`:**
  - On each edge where `s2 != btn_level[i]`: if `dcnt == DEBOUNCE_CYCLES-1`, then `btn_level[i] <= s2` and `dcnt <= 0`; otherwise `dcnt <= dcnt + 1`.
  - On each edge where `s2 == btn_level[i]`: `dcnt <= 0`.
  - Any single-cycle mismatch gap restarts the count.
- **`btn_press[i]`:** registered, high for exactly the one cycle in which `btn_level[i]` first reads 1. There is no pulse on release.
- **Per-bit hold counter `hcnt`:**
  - Cleared while `btn_level[i]` is 0.
  - Increments while the level is 1, and saturates at `LONG_PRESS_CYCLES`.
  - `btn_long[i]` pulses once, on the edge where `hcnt` becomes `LONG_PRESS_CYCLES`.
  - No repeat until the button is released and pressed again.
- **Bit independence:** all eight bits operate independently. Simultaneous presses give simultaneous pulses.
- **Mode register:**
  - On the edge that samples `btn_press[MODE_BTN] == 1`, `mode <= (mode == NUM_MODES-1) ? 0 : mode + 1`, and `mode_changed <= 1`.
  - `mode_changed` is 0 on every other edge.
  - Upper unused bits of `mode` are always 0.
- **Mode button still reported:** `btn_press[MODE_BTN]` and `btn_long[MODE_BTN]` are still driven. Downstream blocks ignore that bit.
- **Reset (asynchronous):** every output, synchroniser flop and counter goes to 0; `mode` goes to 0 (watch).
  - Reset mid-count discards any partial debounce or hold count.
  - A button held high through reset release is treated as a new press: it produces `btn_press` after the normal debounce latency.

## Timing

- **Press latency:** let edge N be the first edge at which `s1` samples a new stable raw value.
  - `s2` changes after edge N+1.
  - `btn_level` and `btn_press` change after edge N+1+DEBOUNCE_CYCLES.
- **Release latency:** same as press latency; no pulse.
- **`btn_long` timing:** asserted exactly `LONG_PRESS_CYCLES` cycles after the `btn_press` cycle, provided the level stays high throughout.
- **`mode` / `mode_changed` timing:** both update one cycle after the `btn_press[MODE_BTN]` cycle.
- **Glitch rejection:** glitches or bounce with runs shorter than `DEBOUNCE_CYCLES` at `s2` never change `btn_level`.
- **No combinational paths:** no combinational path from `btn` to any output.

## Test plan

Bench parameters: `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=10, `MODE_BTN`=0, `NUM_MODES`=3.

- **Reset:** assert `rst` with `btn`=8'hFF mid-run → all outputs 0 immediately (asynchronous); after release, `btn_level` becomes 8'hFF 5 edges after the first sampling edge, with `btn_press`=8'hFF for 1 cycle.
- **Bounce rejection:** `btn[3]` toggles 1,1,1,0,1,1,1,0 per cycle → `btn_level[3]` stays 0, no `btn_press[3]`. Then hold `btn[3]` at 1 → level rises after edge N+5, one `btn_press[3]` pulse.
- **Long press:** hold `btn[5]` for 30 cycles → exactly one `btn_press[5]`; exactly one `btn_long[5]`, 10 cycles later; no pulse on release.
- **Mode wrap:** three clean presses of `btn[0]` → `mode` 0→1→2→0; `mode_changed` pulses 3 times, each one cycle after the matching `btn_press[0]`.
- **Simultaneous press:** `btn[0]` and `btn[1]` rise on the same cycle → `btn_press`=8'h03 on the same cycle; `mode` increments once.
- **Reset mid-debounce:** `btn[2]` rises, `rst` pulses after 2 cycles of count → no `btn_press[2]` before reset; after release, full 5-edge latency applies from scratch.
